// File: rtl/rr_mux_if.sv
// Channel-side and output-side signals of the 4:1 round-robin mux.
// The rr_mux instance attaches through the slave modport; its driver uses master.
interface rr_mux_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
);
  logic [WIDTH-1:0] d_in_0;
  logic [WIDTH-1:0] d_in_1;
  logic [WIDTH-1:0] d_in_2;
  logic [WIDTH-1:0] d_in_3;
  logic             d_valid_0;
  logic             d_valid_1;
  logic             d_valid_2;
  logic             d_valid_3;
  logic             d_ready_0;
  logic             d_ready_1;
  logic             d_ready_2;
  logic             d_ready_3;
  logic [WIDTH-1:0] d_out;
  logic [1:0]       d_sel;
  logic             d_out_valid;
  logic             d_out_ready;
  logic [CNT_W-1:0] d_count;

  modport master (
    output d_in_0, d_in_1, d_in_2, d_in_3,
    output d_valid_0, d_valid_1, d_valid_2, d_valid_3,
    output d_out_ready,
    input  d_ready_0, d_ready_1, d_ready_2, d_ready_3,
    input  d_out, d_sel, d_out_valid, d_count
  );

  modport slave (
    input  d_in_0, d_in_1, d_in_2, d_in_3,
    input  d_valid_0, d_valid_1, d_valid_2, d_valid_3,
    input  d_out_ready,
    output d_ready_0, d_ready_1, d_ready_2, d_ready_3,
    output d_out, d_sel, d_out_valid, d_count
  );
endinterface

// File: rtl/rr_mux.sv
// 4:1 round-robin mux with a one-entry registered output stage and a
// handshake counter; the grant search starts at the channel after the last winner.
module rr_mux #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic    clk,
  input  logic    rst_n,
  rr_mux_if.slave bus
);

  logic [3:0]       valid_vec;
  logic [WIDTH-1:0] din [4];
  logic [1:0]       ptr;
  logic [1:0]       grant;
  logic [1:0]       idx;
  logic             found;
  logic             load;
  logic             handshake;
  logic [3:0]       ready_vec;

  logic [WIDTH-1:0] out_q;
  logic [1:0]       sel_q;
  logic             valid_q;
  logic [CNT_W-1:0] cnt_q;

  assign valid_vec = {bus.d_valid_3, bus.d_valid_2, bus.d_valid_1, bus.d_valid_0};
  assign din[0]    = bus.d_in_0;
  assign din[1]    = bus.d_in_1;
  assign din[2]    = bus.d_in_2;
  assign din[3]    = bus.d_in_3;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && valid_vec[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

  // rst_n gates load so no channel sees a ready while reset is held
  assign load      = rst_n && (!valid_q || bus.d_out_ready) && (|valid_vec);
  assign handshake = valid_q && bus.d_out_ready;
  assign ready_vec = load ? (4'b0001 << grant) : '0;

  assign bus.d_ready_0   = ready_vec[0];
  assign bus.d_ready_1   = ready_vec[1];
  assign bus.d_ready_2   = ready_vec[2];
  assign bus.d_ready_3   = ready_vec[3];
  assign bus.d_out       = out_q;
  assign bus.d_sel       = sel_q;
  assign bus.d_out_valid = valid_q;
  assign bus.d_count     = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      ptr     <= '0;
    end else if (load) begin
      out_q   <= din[grant];
      sel_q   <= grant;
      valid_q <= 1'b1;
      ptr     <= grant + 2'd1;
    end else if (handshake) begin
      valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (handshake) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_rr_mux.sv
// Bench for rr_mux: directed scenarios plus a randomized run against an
// arithmetic round-robin reference model; a CNT_W=4 instance covers counter wrap.
module tb_rr_mux;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  rr_mux_if #(.WIDTH(8), .CNT_W(16)) bus ();
  rr_mux_if #(.WIDTH(8), .CNT_W(4))  bus4 ();

  rr_mux #(.WIDTH(8), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  rr_mux #(.WIDTH(8), .CNT_W(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] rdy_vec();
    return {bus.d_ready_3, bus.d_ready_2, bus.d_ready_1, bus.d_ready_0};
  endfunction

  task automatic set_valid(input logic [3:0] v);
    bus.d_valid_0 = v[0];
    bus.d_valid_1 = v[1];
    bus.d_valid_2 = v[2];
    bus.d_valid_3 = v[3];
  endtask

  task automatic set_data(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [7:0] d);
    bus.d_in_0 = a;
    bus.d_in_1 = b;
    bus.d_in_2 = c;
    bus.d_in_3 = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    set_valid(4'b0000);
    set_data(8'h00, 8'h00, 8'h00, 8'h00);
    bus.d_out_ready  = 1'b0;
    bus4.d_valid_0   = 1'b0;
    bus4.d_valid_1   = 1'b0;
    bus4.d_valid_2   = 1'b0;
    bus4.d_valid_3   = 1'b0;
    bus4.d_in_0      = 8'h00;
    bus4.d_in_1      = 8'h00;
    bus4.d_in_2      = 8'h00;
    bus4.d_in_3      = 8'h00;
    bus4.d_out_ready = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    set_valid(4'b1111);
    #3;
    checks++;
    if ({bus.d_out, bus.d_sel, bus.d_out_valid, bus.d_count, rdy_vec()} !== 31'd0) begin
      errors++;
      $display("FAIL reset_state: got out=%h sel=%0d vld=%b cnt=%0d rdy=%b, want all zero",
               bus.d_out, bus.d_sel, bus.d_out_valid, bus.d_count, rdy_vec());
    end
    @(posedge clk);
    #1;
    checks++;
    if ({bus.d_out_valid, rdy_vec()} !== 5'd0) begin
      errors++;
      $display("FAIL reset_held: got vld=%b rdy=%b, want 0/0000", bus.d_out_valid, rdy_vec());
    end
  endtask

  task automatic test_single();
    apply_reset();
    set_data(8'h00, 8'h00, 8'hA5, 8'h00);
    set_valid(4'b0100);
    bus.d_out_ready = 1'b1;
    #1;
    checks++;
    if (rdy_vec() !== 4'b0100) begin
      errors++;
      $display("FAIL single_ready: got %b want 0100", rdy_vec());
    end
    step();
    set_valid(4'b0000);
    #1;
    checks++;
    if ({bus.d_out, bus.d_sel, bus.d_out_valid} !== {8'hA5, 2'd2, 1'b1} || bus.d_count !== 16'd0) begin
      errors++;
      $display("FAIL single_out: got out=%h sel=%0d vld=%b cnt=%0d want a5/2/1/0",
               bus.d_out, bus.d_sel, bus.d_out_valid, bus.d_count);
    end
    step();
    checks++;
    if (bus.d_count !== 16'd1 || bus.d_out_valid !== 1'b0 || bus.d_out !== 8'hA5) begin
      errors++;
      $display("FAIL single_drain: got cnt=%0d vld=%b out=%h want 1/0/a5",
               bus.d_count, bus.d_out_valid, bus.d_out);
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    set_data(8'h10, 8'h11, 8'h12, 8'h13);
    set_valid(4'b1111);
    bus.d_out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      checks++;
      if (rdy_vec() !== (4'b0001 << (c % 4))) begin
        errors++;
        $display("FAIL rr_grant[%0d]: got %b want %b", c, rdy_vec(), 4'b0001 << (c % 4));
      end
      step();
      checks++;
      if (bus.d_sel !== 2'(c % 4) || bus.d_out !== 8'(8'h10 + c % 4)) begin
        errors++;
        $display("FAIL rr_out[%0d]: got sel=%0d out=%h want %0d/%h",
                 c, bus.d_sel, bus.d_out, c % 4, 8'h10 + c % 4);
      end
    end
    set_valid(4'b0000);
    step();
    checks++;
    if (bus.d_count !== 16'd8) begin
      errors++;
      $display("FAIL rr_count: got %0d want 8", bus.d_count);
    end
  endtask

  task automatic test_stall();
    apply_reset();
    set_data(8'h00, 8'h3C, 8'h00, 8'h00);
    set_valid(4'b0010);
    bus.d_out_ready = 1'b1;
    step();
    bus.d_out_ready = 1'b0;
    set_data(8'h10, 8'h11, 8'h12, 8'h13);
    set_valid(4'b1111);
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if ({bus.d_out, bus.d_sel, bus.d_out_valid} !== {8'h3C, 2'd1, 1'b1} ||
          rdy_vec() !== 4'b0000 || bus.d_count !== 16'd0) begin
        errors++;
        $display("FAIL stall[%0d]: got out=%h sel=%0d vld=%b rdy=%b cnt=%0d want 3c/1/1/0000/0",
                 c, bus.d_out, bus.d_sel, bus.d_out_valid, rdy_vec(), bus.d_count);
      end
      step();
    end
    bus.d_out_ready = 1'b1;
    #1;
    checks++;
    if (rdy_vec() !== 4'b0100) begin
      errors++;
      $display("FAIL stall_release_grant: got %b want 0100", rdy_vec());
    end
    step();
    checks++;
    if ({bus.d_out, bus.d_sel} !== {8'h12, 2'd2} || bus.d_count !== 16'd1) begin
      errors++;
      $display("FAIL stall_release_out: got out=%h sel=%0d cnt=%0d want 12/2/1",
               bus.d_out, bus.d_sel, bus.d_count);
    end
  endtask

  task automatic test_ptr_wrap();
    apply_reset();
    set_data(8'hA0, 8'hA1, 8'hA2, 8'hA3);
    set_valid(4'b1000);
    bus.d_out_ready = 1'b1;
    #1;
    checks++;
    if (rdy_vec() !== 4'b1000) begin
      errors++;
      $display("FAIL wrap_first: got %b want 1000", rdy_vec());
    end
    step();
    set_valid(4'b1001);
    #1;
    checks++;
    if (rdy_vec() !== 4'b0001) begin
      errors++;
      $display("FAIL wrap_next: got %b want 0001", rdy_vec());
    end
    step();
    checks++;
    if ({bus.d_out, bus.d_sel} !== {8'hA0, 2'd0}) begin
      errors++;
      $display("FAIL wrap_out: got out=%h sel=%0d want a0/0", bus.d_out, bus.d_sel);
    end
  endtask

  task automatic test_reset_mid_stall();
    apply_reset();
    set_data(8'h77, 8'h55, 8'h00, 8'h00);
    set_valid(4'b0001);
    bus.d_out_ready = 1'b1;
    repeat (6) step();
    bus.d_out_ready = 1'b0;
    set_valid(4'b0000);
    #1;
    checks++;
    if (bus.d_count !== 16'd5 || bus.d_out_valid !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre: got cnt=%0d vld=%b want 5/1", bus.d_count, bus.d_out_valid);
    end
    #1;
    set_valid(4'b0001);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.d_out, bus.d_sel, bus.d_out_valid, bus.d_count, rdy_vec()} !== 31'd0) begin
      errors++;
      $display("FAIL midrst_async: got out=%h sel=%0d vld=%b cnt=%0d rdy=%b want all zero",
               bus.d_out, bus.d_sel, bus.d_out_valid, bus.d_count, rdy_vec());
    end
    set_valid(4'b0000);
    #2;
    rst_n = 1'b1;
    repeat (3) step();
    checks++;
    if (bus.d_out_valid !== 1'b0 || bus.d_count !== 16'd0 || rdy_vec() !== 4'b0000) begin
      errors++;
      $display("FAIL midrst_idle: got vld=%b cnt=%0d rdy=%b want 0/0/0000",
               bus.d_out_valid, bus.d_count, rdy_vec());
    end
    set_valid(4'b0010);
    #1;
    checks++;
    if (rdy_vec() !== 4'b0010) begin
      errors++;
      $display("FAIL midrst_first_load: got %b want 0010", rdy_vec());
    end
    step();
    checks++;
    if ({bus.d_out, bus.d_sel, bus.d_out_valid} !== {8'h55, 2'd1, 1'b1}) begin
      errors++;
      $display("FAIL midrst_first_out: got out=%h sel=%0d vld=%b want 55/1/1",
               bus.d_out, bus.d_sel, bus.d_out_valid);
    end
  endtask

  task automatic test_random();
    int         m_ptr;
    int         m_sel;
    int         m_cnt;
    int         g;
    bit         m_valid;
    bit         ld;
    logic [7:0] m_out;
    logic [7:0] data [4];
    logic [3:0] v;
    logic [3:0] exp_rdy;
    logic       rdy;

    apply_reset();
    m_ptr = 0; m_sel = 0; m_cnt = 0; m_valid = 0; m_out = 8'h00;
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 4; k++) data[k] = 8'($urandom);
      v   = 4'($urandom);
      rdy = ($urandom_range(0, 3) != 0);
      set_data(data[0], data[1], data[2], data[3]);
      set_valid(v);
      bus.d_out_ready = rdy;

      g = -1;
      for (int j = 0; j < 4; j++) begin
        if (g < 0 && v[(m_ptr + j) % 4]) g = (m_ptr + j) % 4;
      end
      ld      = (!m_valid || rdy) && (g >= 0);
      exp_rdy = ld ? 4'(1 << g) : 4'b0000;
      #1;
      checks++;
      if (rdy_vec() !== exp_rdy) begin
        errors++;
        $display("FAIL rand_ready[%0d]: got %b want %b", c, rdy_vec(), exp_rdy);
      end
      checks++;
      if ({bus.d_out, bus.d_sel, bus.d_out_valid} !== {m_out, 2'(m_sel), m_valid} ||
          bus.d_count !== 16'(m_cnt)) begin
        errors++;
        $display("FAIL rand_out[%0d]: got out=%h sel=%0d vld=%b cnt=%0d want %h/%0d/%b/%0d",
                 c, bus.d_out, bus.d_sel, bus.d_out_valid, bus.d_count,
                 m_out, m_sel, m_valid, m_cnt);
      end
      step();
      if (m_valid && rdy) m_cnt = (m_cnt + 1) % 65536;
      if (ld) begin
        m_out   = data[g];
        m_sel   = g;
        m_valid = 1;
        m_ptr   = (g + 1) % 4;
      end else if (m_valid && rdy) begin
        m_valid = 0;
      end
    end
  endtask

  task automatic test_count_wrap();
    apply_reset();
    bus4.d_in_0      = 8'h5A;
    bus4.d_valid_0   = 1'b1;
    bus4.d_out_ready = 1'b1;
    repeat (18) step();
    bus4.d_valid_0 = 1'b0;
    #1;
    checks++;
    if (bus4.d_count !== 4'd1) begin
      errors++;
      $display("FAIL count_wrap: got %0d want 1", bus4.d_count);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    clear_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_ptr_wrap();
    test_reset_mid_stall();
    test_random();
    test_count_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
